// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore FSM sequencing the multicycle MIPS datapath.
module mips_multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       ZeroFlag,
  output logic [2:0] ALUControl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] PCSrc,
  output logic       PCEn
);
  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t     state, view;
  logic [2:0] alu_f;
  logic       f_ok, pc_write, branch;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= FETCH;
    else case (state)
      FETCH:   state <= DECODE;
      DECODE:  case (Opcode)
                 OP_LW, OP_SW: state <= MEMADR;
                 OP_R:         state <= EXECUTE;
                 OP_BEQ:       state <= BRANCH;
                 OP_ADDI:      state <= ADDIEX;
                 OP_J:         state <= JUMP;
                 default:      state <= FETCH;
               endcase
      MEMADR:  state <= (Opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state <= MEMWB;
      EXECUTE: state <= ALUWB;
      ADDIEX:  state <= ADDIWB;
      default: state <= FETCH;
    endcase
  end
  always_comb begin
    f_ok = 1'b1;
    case (Funct)
      6'b100000: alu_f = 3'b010;
      6'b100010: alu_f = 3'b100;
      6'b100100: alu_f = 3'b000;
      6'b100101: alu_f = 3'b001;
      6'b101010: alu_f = 3'b110;
      6'b011000: alu_f = 3'b101;
      default: begin alu_f = 3'b010; f_ok = 1'b0; end
    endcase
  end
  // In reset the decode shows FETCH, with its write enables gated by RST.
  assign view = RST ? state : FETCH;
  always_comb begin
    ALUControl = 3'b010;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    PCSrc      = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (view)
      FETCH:   begin ALUSrcB = 2'b01; IRWrite = RST; pc_write = RST; end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      MEMRD:   IorD = 1'b1;
      MEMWB:   begin MemtoReg = 1'b1; RegWrite = 1'b1; end
      MEMWR:   begin IorD = 1'b1; MemWrite = 1'b1; end
      EXECUTE: begin ALUSrcA = 1'b1; ALUControl = alu_f; end
      ALUWB:   begin RegDst = 1'b1; RegWrite = f_ok; end
      BRANCH:  begin ALUSrcA = 1'b1; ALUControl = 3'b100; PCSrc = 2'b01; branch = 1'b1; end
      ADDIEX:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      ADDIWB:  RegWrite = 1'b1;
      JUMP:    begin PCSrc = 2'b10; pc_write = 1'b1; end
      default: ;
    endcase
  end
  assign PCEn = pc_write | (branch & ZeroFlag);
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed per-cycle checks of the multicycle control FSM.
module tb_mips_multicycle_control;
  logic       CLK = 1'b0, RST = 1'b0, ZeroFlag = 1'b0;
  logic [5:0] Opcode = 6'b0, Funct = 6'b0;
  logic [2:0] ALUControl;
  logic       ALUSrcA, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [14:0] obs;
  int n = 0, p = 0;

  mips_multicycle_control dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .ZeroFlag(ZeroFlag),
    .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .PCSrc(PCSrc), .PCEn(PCEn)
  );

  always #5 CLK = ~CLK;
  assign obs = {ALUControl, ALUSrcA, ALUSrcB, IorD, IRWrite, MemWrite, RegWrite,
                RegDst, MemtoReg, PCSrc, PCEn};

  function automatic logic [14:0] mk(logic [2:0] alu, logic a, logic [1:0] b, logic iord,
                                     logic irw, logic mw, logic rw, logic rd, logic m2r,
                                     logic [1:0] pcs, logic pcen);
    return {alu, a, b, iord, irw, mw, rw, rd, m2r, pcs, pcen};
  endfunction

  task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
    n++;
    if (o !== e) $display("FAIL %s: got %h expected %h", tag, o, e);
    else p++;
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  logic [14:0] e_fetch, e_rst, e_dec, e_madr, e_mrd, e_mwb, e_mwr, e_aex, e_awbi, e_j;
  logic [5:0] fn [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000, 6'b111111};
  logic [2:0] fa [7] = '{3'b010, 3'b100, 3'b000, 3'b001, 3'b110, 3'b101, 3'b010};
  logic       fw [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    e_fetch = mk(3'b010, 0, 2'b01, 0, 1, 0, 0, 0, 0, 2'b00, 1);
    e_rst   = mk(3'b010, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    e_dec   = mk(3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    e_madr  = mk(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    e_mrd   = mk(3'b010, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    e_mwb   = mk(3'b010, 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0);
    e_mwr   = mk(3'b010, 0, 2'b00, 1, 0, 1, 0, 0, 0, 2'b00, 0);
    e_aex   = mk(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    e_awbi  = mk(3'b010, 0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0);
    e_j     = mk(3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1);
    // Reset held across edges
    step; step;
    chk("rst_hold", obs, e_rst);
    @(negedge CLK); RST = 1'b1; #1;
    chk("rst_release_fetch", obs, e_fetch);
    // lw: 5 cycles
    Opcode = 6'b100011;
    step; chk("lw_decode", obs, e_dec);
    step; chk("lw_memadr", obs, e_madr);
    step; chk("lw_memrd", obs, e_mrd);
    step; chk("lw_memwb", obs, e_mwb);
    step; chk("lw_fetch", obs, e_fetch);
    // R-type sweep: 4 cycles each
    Opcode = 6'b000000;
    for (int i = 0; i < 7; i++) begin
      Funct = fn[i];
      step; chk($sformatf("r%0d_decode", i), obs, e_dec);
      step; chk($sformatf("r%0d_execute", i), obs, mk(fa[i], 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0));
      step; chk($sformatf("r%0d_aluwb", i), obs, mk(3'b010, 0, 2'b00, 0, 0, 0, fw[i], 1, 0, 2'b00, 0));
      step; chk($sformatf("r%0d_fetch", i), obs, e_fetch);
    end
    // beq taken / not taken: 3 cycles each
    Opcode = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      ZeroFlag = z[0];
      step; chk($sformatf("beq%0d_decode", z), obs, e_dec);
      step; chk($sformatf("beq%0d_branch", z), obs, mk(3'b100, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, z[0]));
      step; chk($sformatf("beq%0d_fetch", z), obs, e_fetch);
    end
    // ZeroFlag must not leak into PCEn outside BRANCH
    ZeroFlag = 1'b1;
    Opcode = 6'b001000;
    step; chk("addi_decode", obs, e_dec);
    step; chk("addi_ex", obs, e_aex);
    step; chk("addi_wb", obs, e_awbi);
    step; chk("addi_fetch", obs, e_fetch);
    ZeroFlag = 1'b0;
    Opcode = 6'b101011;
    step; chk("sw_decode", obs, e_dec);
    step; chk("sw_memadr", obs, e_madr);
    step; chk("sw_memwr", obs, e_mwr);
    step; chk("sw_fetch", obs, e_fetch);
    Opcode = 6'b000010;
    step; chk("j_decode", obs, e_dec);
    step; chk("j_jump", obs, e_j);
    step; chk("j_fetch", obs, e_fetch);
    Opcode = 6'b111111;
    step; chk("ill_decode", obs, e_dec);
    step; chk("ill_fetch", obs, e_fetch);
    // Asynchronous reset in the middle of MEMRD
    Opcode = 6'b100011;
    step; step; step;
    chk("abort_memrd", obs, e_mrd);
    #2 RST = 1'b0; #1;
    chk("abort_async", obs, e_rst);
    step; chk("abort_no_regwrite", obs, e_rst);
    @(negedge CLK); RST = 1'b1; #1;
    chk("abort_restart_fetch", obs, e_fetch);
    step; chk("abort_restart_decode", obs, e_dec);
    $display("%0d/%0d checks passed", p, n);
    $finish;
  end
endmodule
